// File: rtl/busreq_pkg.sv
// Shared state encodings and direction constants for the multi-channel
// DMA bus-request arbiter.
package busreq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARB  = 2'b01,
        REQ  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/busreq_arb_if.sv
// Channel status, AHB-master request handshake and address-update strobes
// exchanged between the arbiter and the DMA channels / AHB master.
interface busreq_arb_if #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
);
    logic [NCH-1:0]  dma_en;
    logic [NCH-1:0]  fifo_full;
    logic [NCH-1:0]  fifo_empty;
    logic [NCH-1:0]  non_zero;
    logic            req_done;
    logic            req;
    logic            req_wr;
    logic [CH_W-1:0] req_ch;
    logic [NCH-1:0]  wr_update;
    logic [NCH-1:0]  rd_update;
    logic            busy;

    // Arbiter side: issues requests and update strobes.
    modport master (
        input  dma_en, fifo_full, fifo_empty, non_zero, req_done,
        output req, req_wr, req_ch, wr_update, rd_update, busy
    );

    // Channel / AHB-master side.
    modport slave (
        output dma_en, fifo_full, fifo_empty, non_zero, req_done,
        input  req, req_wr, req_ch, wr_update, rd_update, busy
    );
endinterface

// File: rtl/busreq_arb_rr_pick.sv
// Rotating priority encoder: the lowest ready index at or above start wins;
// if none exists the search wraps and the lowest ready index overall wins.
module rr_pick #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic [NCH-1:0]  rdy,
    input  logic [CH_W-1:0] start,
    output logic            vld,
    output logic [CH_W-1:0] idx
);
    logic            hi_vld;
    logic [CH_W-1:0] hi_idx;

    always_comb begin
        vld    = 1'b0;
        idx    = '0;
        hi_vld = 1'b0;
        hi_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                vld = 1'b1;
                idx = CH_W'(i);
                if (CH_W'(i) >= start) begin
                    hi_vld = 1'b1;
                    hi_idx = CH_W'(i);
                end
            end
        end
        if (hi_vld) idx = hi_idx;
    end
endmodule

// File: rtl/busreq_arb.sv
// Multi-channel DMA bus-request arbiter: round-robin channel choice with
// per-channel read/write alternation, one AHB request in flight at a time.
module busreq_arb
    import busreq_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic         hclk,
    input  logic         hresetn,
    busreq_arb_if.master bus
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [NCH-1:0]  last_dir;
    logic            req_q;
    logic            req_wr_q;
    logic [CH_W-1:0] req_ch_q;
    logic [NCH-1:0]  wr_upd_q;
    logic [NCH-1:0]  rd_upd_q;
    logic            busy_q;

    logic [NCH-1:0]  wr_rdy;
    logic [NCH-1:0]  rd_rdy;
    logic [NCH-1:0]  any_rdy;
    logic            pick_vld;
    logic [CH_W-1:0] pick_ch;
    logic            pick_wr;
    logic [NCH-1:0]  ch_onehot;

    assign wr_rdy  = bus.dma_en & ~bus.fifo_empty;
    assign rd_rdy  = bus.dma_en & ~bus.fifo_full & bus.non_zero;
    assign any_rdy = wr_rdy | rd_rdy;

    rr_pick #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_pick (
        .rdy   (any_rdy),
        .start (rr_ptr),
        .vld   (pick_vld),
        .idx   (pick_ch)
    );

    // A channel ready both ways flips away from the direction it last used.
    always_comb begin
        pick_wr = wr_rdy[pick_ch];
        if (wr_rdy[pick_ch] && rd_rdy[pick_ch]) pick_wr = ~last_dir[pick_ch];
    end

    assign ch_onehot = NCH'(1) << req_ch_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            last_dir <= '0;
            req_q    <= 1'b0;
            req_wr_q <= DIR_RD;
            req_ch_q <= '0;
            wr_upd_q <= '0;
            rd_upd_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_upd_q <= '0;
            rd_upd_q <= '0;
            case (state)
                IDLE: begin
                    if (|bus.dma_en) begin
                        state  <= ARB;
                        busy_q <= 1'b1;
                    end
                end
                ARB: begin
                    if (pick_vld) begin
                        state    <= REQ;
                        req_q    <= 1'b1;
                        req_ch_q <= pick_ch;
                        req_wr_q <= pick_wr;
                    end else if (~|bus.dma_en) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                REQ: begin
                    // Request runs to completion even if the channel drops its enable.
                    if (bus.req_done) begin
                        state <= DONE;
                        req_q <= 1'b0;
                        if (req_wr_q == DIR_WR) wr_upd_q <= ch_onehot;
                        else                    rd_upd_q <= ch_onehot;
                    end
                end
                DONE: begin
                    last_dir[req_ch_q] <= req_wr_q;
                    rr_ptr             <= (req_ch_q == LAST_CH) ? '0 : req_ch_q + CH_W'(1);
                    state              <= ARB;
                end
                default: begin
                    state  <= IDLE;
                    req_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req       = req_q;
    assign bus.req_wr    = req_wr_q;
    assign bus.req_ch    = req_ch_q;
    assign bus.wr_update = wr_upd_q;
    assign bus.rd_update = rd_upd_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_busreq_arb.sv
// Scoreboard bench for busreq_arb: directed scenarios plus random channel
// status, checked against a rule-level arbitration model.
module tb_busreq_arb;
    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef struct {
        int ch;
        bit wr;
    } grant_t;

    typedef struct {
        logic [NCH-1:0] wu;
        logic [NCH-1:0] ru;
    } strobe_t;

    logic hclk = 1'b0;
    logic hresetn;

    busreq_arb_if #(.NCH(NCH), .CH_W(CH_W)) bus ();

    busreq_arb #(.NCH(NCH), .CH_W(CH_W)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    grant_t  exp_grant[$];
    strobe_t exp_strobe[$];

    // Reference model state: next search start and last direction per channel.
    int m_rr;
    bit m_last[NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void predict(input logic [NCH-1:0] en, input logic [NCH-1:0] fe,
                                    input logic [NCH-1:0] ff, input logic [NCH-1:0] nz,
                                    output bit found, output int ch, output bit wr);
        int c;
        bit w;
        bit r;
        found = 0;
        ch    = 0;
        wr    = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            w = en[c] && !fe[c];
            r = en[c] && !ff[c] && nz[c];
            if (!found && (w || r)) begin
                found = 1;
                ch    = c;
                wr    = (w && r) ? !m_last[c] : w;
            end
        end
    endfunction

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < NCH; i++) m_last[i] = 0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge hclk);
            if (bus.req) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'(bus.req), 32'd1);
    endtask

    task automatic pulse_done();
        bus.req_done = 1'b1;
        @(negedge hclk);
        bus.req_done = 1'b0;
    endtask

    // One transaction: apply status, predict, optionally disturb inputs during
    // REQ, complete after dly cycles. Returns on the update-strobe cycle.
    task automatic do_txn(input logic [NCH-1:0] en, input logic [NCH-1:0] fe,
                          input logic [NCH-1:0] ff, input logic [NCH-1:0] nz,
                          input int dly, input int mode);
        bit      found;
        bit      wr;
        bit      ok;
        int      ch;
        grant_t  g;
        strobe_t s;
        bus.dma_en     = en;
        bus.fifo_empty = fe;
        bus.fifo_full  = ff;
        bus.non_zero   = nz;
        predict(en, fe, ff, nz, found, ch, wr);
        if (!found) begin
            repeat (4) @(negedge hclk);
            check("no_grant_req", 32'(bus.req), 32'd0);
            return;
        end
        g.ch = ch;
        g.wr = wr;
        exp_grant.push_back(g);
        wait_req(ok);
        if (!ok) return;
        case (mode)
            1: bus.dma_en[ch] = 1'b0;
            2: begin
                bus.fifo_empty[ch] = 1'b1;
                bus.fifo_full[ch]  = ~bus.fifo_full[ch];
            end
            3: begin
                bus.dma_en     = NCH'($urandom);
                bus.fifo_empty = NCH'($urandom);
                bus.fifo_full  = NCH'($urandom);
                bus.non_zero   = NCH'($urandom);
            end
            default: ;
        endcase
        repeat (dly) @(negedge hclk);
        s.wu = wr ? (NCH'(1) << ch) : '0;
        s.ru = wr ? '0 : (NCH'(1) << ch);
        exp_strobe.push_back(s);
        pulse_done();
        m_last[ch] = wr;
        m_rr       = (ch + 1) % NCH;
        check("strobe_latency", 32'((bus.wr_update | bus.rd_update) != '0), 32'd1);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or strobe.
    initial begin : monitor
        bit     prev_req;
        grant_t cur;
        prev_req = 0;
        cur.ch   = 0;
        cur.wr   = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                prev_req = 0;
                continue;
            end
            if (bus.req && !prev_req) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_req", 32'(bus.req), 32'd0);
                end else begin
                    cur = exp_grant.pop_front();
                    check("grant_ch", 32'(bus.req_ch), 32'(cur.ch));
                    check("grant_wr", 32'(bus.req_wr), 32'(cur.wr));
                    check("busy_in_req", 32'(bus.busy), 32'd1);
                end
            end else if (bus.req) begin
                check("hold_ch", 32'(bus.req_ch), 32'(cur.ch));
                check("hold_wr", 32'(bus.req_wr), 32'(cur.wr));
            end
            if ((bus.wr_update | bus.rd_update) != '0) begin
                if (exp_strobe.size() == 0) begin
                    check("unexpected_strobe", 32'({bus.wr_update, bus.rd_update}), 32'd0);
                end else begin
                    strobe_t s;
                    s = exp_strobe.pop_front();
                    check("wr_update", 32'(bus.wr_update), 32'(s.wu));
                    check("rd_update", 32'(bus.rd_update), 32'(s.ru));
                    check("req_low_in_done", 32'(bus.req), 32'd0);
                end
            end
            prev_req = bus.req;
        end
    end

    initial begin : stimulus
        bit     ok;
        bit     found;
        bit     wr;
        int     ch;
        grant_t g;

        hresetn        = 1'b0;
        bus.dma_en     = '0;
        bus.fifo_empty = '1;
        bus.fifo_full  = '1;
        bus.non_zero   = '0;
        bus.req_done   = 1'b0;
        model_reset();
        repeat (3) @(negedge hclk);
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_wr", 32'(bus.req_wr), 32'd0);
        check("rst_req_ch", 32'(bus.req_ch), 32'd0);
        check("rst_updates", 32'({bus.wr_update, bus.rd_update}), 32'd0);
        hresetn = 1'b1;
        @(negedge hclk);

        // Round robin, write-ready only.
        for (int i = 0; i < 5; i++) do_txn(4'b1111, 4'b0000, 4'b1111, 4'b1111, 2, 0);

        // Skip and wrap: land rr_ptr on 3, then only ch1 ready, then all.
        do_txn(4'b0100, 4'b0000, 4'b1111, 4'b1111, 1, 0);
        do_txn(4'b0010, 4'b0000, 4'b1111, 4'b1111, 1, 0);
        do_txn(4'b1111, 4'b0000, 4'b1111, 4'b1111, 1, 0);

        // Single channel both-ready alternation, including accept-on-first-cycle.
        for (int i = 0; i < 4; i++) do_txn(4'b0001, 4'b0000, 4'b0000, 4'b0001, (i == 3) ? 0 : 3, 0);

        // dma_en[2] dropped mid-request, then ch2 stays out.
        do_txn(4'b0100, 4'b0000, 4'b1111, 4'b1111, 2, 1);
        for (int i = 0; i < 3; i++) do_txn(4'b1011, 4'b0000, 4'b1111, 4'b1111, 1, 0);

        // fifo_empty[1] rising during a ch1 write request.
        do_txn(4'b0010, 4'b0000, 4'b1111, 4'b1111, 3, 2);

        // Stray req_done while parked in ARB, then in IDLE.
        bus.dma_en     = 4'b0001;
        bus.fifo_empty = 4'b1111;
        bus.fifo_full  = 4'b1111;
        bus.non_zero   = 4'b0000;
        repeat (3) @(negedge hclk);
        check("busy_arb_wait", 32'(bus.busy), 32'd1);
        pulse_done();
        repeat (3) @(negedge hclk);
        check("stray_arb_req", 32'(bus.req), 32'd0);
        check("stray_arb_busy", 32'(bus.busy), 32'd1);
        bus.dma_en = 4'b0000;
        repeat (3) @(negedge hclk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        pulse_done();
        repeat (3) @(negedge hclk);
        check("stray_idle_busy", 32'(bus.busy), 32'd0);
        check("stray_idle_req", 32'(bus.req), 32'd0);

        // Reset while a request is outstanding.
        do_txn(4'b0001, 4'b0000, 4'b1111, 4'b1111, 1, 0);
        bus.dma_en     = 4'b1111;
        bus.fifo_empty = 4'b0000;
        bus.fifo_full  = 4'b1111;
        bus.non_zero   = 4'b1111;
        predict(bus.dma_en, bus.fifo_empty, bus.fifo_full, bus.non_zero, found, ch, wr);
        g.ch = ch;
        g.wr = wr;
        exp_grant.push_back(g);
        wait_req(ok);
        #2 hresetn = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus.req), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        bus.dma_en = 4'b0000;
        exp_grant.delete();
        exp_strobe.delete();
        model_reset();
        @(negedge hclk);
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        do_txn(4'b1111, 4'b0000, 4'b1111, 4'b1111, 1, 0);

        // Random channel status with random mid-request disturbance.
        for (int i = 0; i < 60; i++)
            do_txn(NCH'($urandom_range(1, 15)), NCH'($urandom), NCH'($urandom), NCH'($urandom),
                   $urandom_range(0, 4), $urandom_range(0, 3));

        // Everything disabled: back to IDLE.
        bus.dma_en = 4'b0000;
        repeat (5) @(negedge hclk);
        check("final_busy", 32'(bus.busy), 32'd0);
        check("final_req", 32'(bus.req), 32'd0);
        check("grants_drained", 32'(exp_grant.size()), 32'd0);
        check("strobes_drained", 32'(exp_strobe.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
